knn_label_packer: RTL and testbench
===================================

KNN_LABEL_PACKER -- requirements
Module: knn_label_packer

Interface
REQ-001 Parameter PW, default 512, LII packing width in bits.
REQ-002 Parameter LW, default 8, label width; labels per beat LPB = PW/LW (64 at defaults).
REQ-003 Parameter TOTAL, default 2000, labels per job; range 1..65535.
REQ-004 Parameter TIMEOUT, default 1024, idle cycles before a partial beat is flushed; must be >= 1.
REQ-005 Parameters SRC_ID, default 8'h00, and DST_ID, default 8'h00, are the tags driven on the output.
REQ-006 aclk  in  1  single clock; all state changes on its rising edge.
REQ-007 arstn  in  1  reset; asynchronous assertion, active-low.
REQ-008 in_tdata  in  PW  KNN result beat; label in bits [LW-1:0], remaining bits ignored.
REQ-009 in_tvalid / in_tready  in / out  1 each  input handshake.
REQ-010 in_src / in_dst  in  8 each  LII tags; accepted and ignored.
REQ-011 out_tdata  out  PW  packed labels; slot k occupies bits [LW*k+LW-1:LW*k].
REQ-012 out_tvalid / out_tready  out / in  1 each  output handshake.
REQ-013 out_src / out_dst  out  8 each  constant SRC_ID / DST_ID.
REQ-014 out_count  out  7  number of valid slots in the current out beat, 1..LPB.
REQ-015 job_done  out  1  one-cycle pulse on the handshake of the last beat of a job.

Function
REQ-016 The FSM has two states: FILL and SEND.
REQ-017 In FILL: in_tready=1, out_tvalid=0; on accept (in_tvalid & in_tready), label goes to slot idx, idx increments, job counter jcnt increments.
REQ-018 FILL->SEND on the accept that fills slot LPB-1, or on the accept that makes jcnt reach TOTAL.
REQ-019 FILL->SEND after TIMEOUT consecutive FILL cycles with idx>0 and no accept; the idle counter clears on every accept and whenever idx=0.
REQ-020 out_tvalid rises the cycle after the transition-causing accept (latency 1); a timeout flush asserts out_tvalid the cycle after the counter reaches TIMEOUT.
REQ-021 In SEND: in_tready=0, out_tvalid=1; out_tdata, out_count and job_done conditions stay stable until out_tready.
REQ-022 Slots at or above out_count read zero.
REQ-023 On the SEND handshake: buffer clears to zero, idx=0, state returns to FILL.
REQ-024 On the SEND handshake, if jcnt=TOTAL: job_done=1 for that cycle only, and jcnt returns to 0.
REQ-025 A timeout flush does not reset jcnt; the job continues across partial beats.
REQ-026 There are no simultaneous accept and send, because in_tready=0 in SEND; the maximum rate is LPB labels per LPB+1 cycles.
REQ-027 No label is dropped or duplicated under any out_tready pattern.

Reset
REQ-028 While arstn=0: state=FILL, idx=0, jcnt=0, idle counter=0, buffer=0, out_tvalid=0, in_tready=0, job_done=0, out_count=0.
REQ-029 in_tready rises in the first cycle after arstn deasserts.
REQ-030 A reset mid-fill or mid-send discards the partial beat with no output, and the next beat starts at slot 0.

Verification
REQ-031 Defaults, 64 labels 0..63 back-to-back with out_tready=1 -> one beat with byte k=k, out_count=64, out_tvalid high the cycle after the 64th accept.
REQ-032 TOTAL=70, labels 0..69 -> beat 1 holds 0..63 (count 64); beat 2 holds 64..69 in slots 0..5 with slots 6..63 zero (count 6); job_done pulses only on the beat-2 handshake.
REQ-033 TIMEOUT=16, 5 labels then idle -> out_tvalid asserted exactly 16 idle cycles after the 5th accept; out_count=5; a following label lands in slot 0, and jcnt continues from 5.
REQ-034 out_tready held low 10 cycles during SEND -> out_tdata/out_count stable, in_tready=0, no input accepted; after release, all labels are present exactly once.
REQ-035 arstn pulsed low after 30 accepted labels -> no output beat; the next 64 labels form one full beat starting at slot 0.
REQ-036 in_tdata[PW-1:LW]=all ones, with random in_src/in_dst -> the output is identical to the same labels with zero upper bits.

Source files
------------

// File: rtl/knn_label_packer.sv
// knn_label_packer: packs LW-bit KNN labels into PW-bit beats, flushing on full beat, job end or idle timeout
module knn_label_packer #(
   parameter int         PW      = 512,
   parameter int         LW      = 8,
   parameter int         TOTAL   = 2000,
   parameter int         TIMEOUT = 1024,
   parameter logic [7:0] SRC_ID  = 8'h00,
   parameter logic [7:0] DST_ID  = 8'h00
) (
   input  logic          aclk,
   input  logic          arstn,
   input  logic [PW-1:0] in_tdata,
   input  logic          in_tvalid,
   output logic          in_tready,
   input  logic [7:0]    in_src,
   input  logic [7:0]    in_dst,
   output logic [PW-1:0] out_tdata,
   output logic          out_tvalid,
   input  logic          out_tready,
   output logic [7:0]    out_src,
   output logic [7:0]    out_dst,
   output logic [6:0]    out_count,
   output logic          job_done
);
   localparam int LPB = PW / LW;
   localparam int XW  = $clog2(LPB + 1);
   localparam int TW  = $clog2(TIMEOUT + 1);

   typedef enum logic {FILL, SEND} state_t;

   state_t        state, state_nx;
   logic          run;
   logic [XW-1:0] idx;
   logic [15:0]   jcnt;
   logic [TW-1:0] icnt;
   logic [PW-1:0] buf_q;
   logic          acc, snd, full, last, tmo, unused_ok;

   assign acc  = in_tvalid & in_tready;
   assign snd  = out_tvalid & out_tready;
   assign full = idx == XW'(LPB - 1);
   assign last = jcnt == 16'(TOTAL - 1);
   assign tmo  = idx != '0 && icnt == TW'(TIMEOUT - 1);

   assign out_tdata = buf_q;
   assign out_count = 7'(idx);
   assign out_src   = SRC_ID;
   assign out_dst   = DST_ID;
   assign job_done  = snd && jcnt == 16'(TOTAL);
   assign unused_ok = ^{in_src, in_dst, in_tdata[PW-1:LW]};

   // next state and handshake outputs; ready is held off until the first clock after reset
   always_comb begin
      state_nx   = state;
      in_tready  = 1'b0;
      out_tvalid = 1'b0;
      if (state == FILL) begin
         in_tready = run;
         state_nx  = ((acc && (full || last)) || (!acc && tmo)) ? SEND : FILL;
      end else begin
         out_tvalid = 1'b1;
         state_nx   = out_tready ? FILL : SEND;
      end
   end

   // state, slot buffer, job and idle counters
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         state <= FILL;
         run   <= 1'b0;
         idx   <= '0;
         jcnt  <= '0;
         icnt  <= '0;
         buf_q <= '0;
      end else begin
         state <= state_nx;
         run   <= 1'b1;
         icnt  <= (state == FILL && !acc && idx != '0) ? icnt + 1'b1 : '0;
         if (acc) begin
            idx  <= idx + 1'b1;
            jcnt <= jcnt + 1'b1;
         end
         if (snd) begin
            buf_q <= '0;
            idx   <= '0;
            if (jcnt == 16'(TOTAL)) jcnt <= '0;
         end else begin
            for (int k = 0; k < LPB; k++)
               if (acc && idx == XW'(k)) buf_q[k*LW +: LW] <= in_tdata[LW-1:0];
         end
      end
   end
endmodule

// File: tb/tb_knn_label_packer.sv
// tb_knn_label_packer: directed checks of full, job-end, timeout, stall and reset behaviour
module tb_knn_label_packer;
   localparam int PW = 512;

   logic          aclk = 1'b0;
   logic          arstn;
   logic [PW-1:0] in_tdata;
   logic          in_tvalid;
   logic          in_tready;
   logic [7:0]    in_src, in_dst;
   logic [PW-1:0] out_tdata;
   logic          out_tvalid;
   logic          out_tready;
   logic [7:0]    out_src, out_dst;
   logic [6:0]    out_count;
   logic          job_done;
   int            vecs = 0;
   int            errs = 0;

   knn_label_packer #(
      .PW(PW), .LW(8), .TOTAL(70), .TIMEOUT(16), .SRC_ID(8'hA5), .DST_ID(8'h3C)
   ) dut (
      .aclk(aclk), .arstn(arstn),
      .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
      .in_src(in_src), .in_dst(in_dst),
      .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
      .out_src(out_src), .out_dst(out_dst), .out_count(out_count), .job_done(job_done)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chkd(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      vecs++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] beat(input int s, input int n);
      logic [PW-1:0] b = '0;
      for (int k = 0; k < n; k++) b[k*8 +: 8] = 8'(s + k);
      return b;
   endfunction

   task automatic put(input logic [7:0] l, input bit hi);
      in_tdata  = hi ? {{(PW-8){1'b1}}, l} : {{(PW-8){1'b0}}, l};
      in_src    = 8'($urandom);
      in_dst    = 8'($urandom);
      in_tvalid = 1'b1;
      @(posedge aclk); #1;
   endtask

   initial begin
      logic [PW-1:0] e;
      in_tdata = '0; in_tvalid = 1'b0; out_tready = 1'b1; in_src = '0; in_dst = '0; arstn = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_in_tready", 32'(in_tready), 32'(0));
      chk("rst_out_tvalid", 32'(out_tvalid), 32'(0));
      chk("rst_job_done", 32'(job_done), 32'(0));
      chk("rst_out_count", 32'(out_count), 32'(0));
      chkd("rst_out_tdata", out_tdata, '0);
      arstn = 1'b1;
      @(posedge aclk); #1;
      chk("post_rst_ready", 32'(in_tready), 32'(1));
      // full beat of 0..63
      for (int k = 0; k < 64; k++) begin
         if (k == 63) chk("a_no_early_valid", 32'(out_tvalid), 32'(0));
         put(8'(k), 1'b0);
      end
      in_tvalid = 1'b0;
      chk("a_valid", 32'(out_tvalid), 32'(1));
      chkd("a_data", out_tdata, beat(0, 64));
      chk("a_count", 32'(out_count), 32'(64));
      chk("a_job_done", 32'(job_done), 32'(0));
      chk("a_in_tready", 32'(in_tready), 32'(0));
      chk("a_src", 32'(out_src), 32'(8'hA5));
      chk("a_dst", 32'(out_dst), 32'(8'h3C));
      @(posedge aclk); #1;
      chk("a_after_valid", 32'(out_tvalid), 32'(0));
      chk("a_after_ready", 32'(in_tready), 32'(1));
      // job end: labels 64..69 finish the 70-label job
      for (int k = 64; k < 70; k++) put(8'(k), 1'b0);
      in_tvalid = 1'b0;
      chk("b_valid", 32'(out_tvalid), 32'(1));
      chk("b_count", 32'(out_count), 32'(6));
      chkd("b_data", out_tdata, beat(64, 6));
      chk("b_job_done", 32'(job_done), 32'(1));
      @(posedge aclk); #1;
      chk("b_job_done_pulse", 32'(job_done), 32'(0));
      chk("b_after_valid", 32'(out_tvalid), 32'(0));
      // timeout flush after 5 labels, with output stalled
      out_tready = 1'b0;
      for (int k = 10; k < 15; k++) put(8'(k), 1'b0);
      in_tvalid = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         chk("c_idle_no_valid", 32'(out_tvalid), 32'(0));
         @(posedge aclk); #1;
      end
      chk("c_tmo_valid", 32'(out_tvalid), 32'(1));
      chk("c_tmo_count", 32'(out_count), 32'(5));
      chkd("c_tmo_data", out_tdata, beat(10, 5));
      chk("c_tmo_job_done", 32'(job_done), 32'(0));
      in_tdata  = {{(PW-8){1'b0}}, 8'h77};
      in_tvalid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("c_stall_valid", 32'(out_tvalid), 32'(1));
         chk("c_stall_ready", 32'(in_tready), 32'(0));
         chk("c_stall_count", 32'(out_count), 32'(5));
         chkd("c_stall_data", out_tdata, beat(10, 5));
         @(posedge aclk); #1;
      end
      out_tready = 1'b1;
      @(posedge aclk); #1;
      chk("c_release_valid", 32'(out_tvalid), 32'(0));
      put(8'h77, 1'b0);
      for (int k = 1; k < 64; k++) put(8'(k), 1'b0);
      in_tvalid = 1'b0;
      e = beat(0, 64);
      e[7:0] = 8'h77;
      chk("c_next_valid", 32'(out_tvalid), 32'(1));
      chk("c_next_count", 32'(out_count), 32'(64));
      chkd("c_next_data", out_tdata, e);
      chk("c_next_job_done", 32'(job_done), 32'(0));
      @(posedge aclk); #1;
      put(8'hC8, 1'b0);
      in_tvalid = 1'b0;
      chk("c_end_valid", 32'(out_tvalid), 32'(1));
      chk("c_end_count", 32'(out_count), 32'(1));
      chkd("c_end_data", out_tdata, beat(200, 1));
      chk("c_end_job_done", 32'(job_done), 32'(1));
      @(posedge aclk); #1;
      chk("c_end_pulse", 32'(job_done), 32'(0));
      // reset mid-fill, then a full beat with upper data bits set
      for (int k = 0; k < 30; k++) put(8'(k), 1'b0);
      in_tvalid = 1'b0;
      arstn = 1'b0;
      #1;
      chk("d_rst_valid", 32'(out_tvalid), 32'(0));
      chk("d_rst_ready", 32'(in_tready), 32'(0));
      chk("d_rst_count", 32'(out_count), 32'(0));
      @(posedge aclk); #1;
      arstn = 1'b1;
      @(posedge aclk); #1;
      chk("d_no_output", 32'(out_tvalid), 32'(0));
      for (int k = 0; k < 64; k++) put(8'(100 + k), 1'b1);
      in_tvalid = 1'b0;
      chk("d_valid", 32'(out_tvalid), 32'(1));
      chk("d_count", 32'(out_count), 32'(64));
      chkd("d_data", out_tdata, beat(100, 64));
      chk("d_job_done", 32'(job_done), 32'(0));
      @(posedge aclk); #1;
      chk("d_after_valid", 32'(out_tvalid), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
